minirisc_driver: RTL and testbench

MINIRISC_DRIVER -- requirements
Module: minirisc_driver

---
 rtl/minirisc_pkg.sv | 21 ++
 rtl/minirisc_driver_sat_counter8.sv | 21 ++
 rtl/minirisc_driver.sv | 117 +++++++++++
 tb/tb_minirisc_driver.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/minirisc_pkg.sv
// Shared definitions for the minirisc core driver: FSM encoding, the
// increment the core is expected to apply, and the edges at which it is sampled.
package minirisc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE1 = 3'd1,
        ST_ISSUE2 = 3'd2,
        ST_WAIT   = 3'd3,
        ST_ECHO   = 3'd4,
        ST_SUM    = 3'd5,
        ST_RESP   = 3'd6
    } state_t;

    localparam logic [7:0] ADD_CONST_DEFAULT = 8'h08;

    // Edges after operand accept (E0) at which the core output is sampled.
    localparam int ECHO_SAMPLE_EDGE = 4;
    localparam int SUM_SAMPLE_EDGE  = 5;

endpackage

// File: rtl/minirisc_driver_sat_counter8.sv
// 8-bit event counter with synchronous clear that sticks at 255.
module sat_counter8 (
    input  logic       clk,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] count
);

    logic [7:0] r_count;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_count <= 8'h00;
        end else if (inc && (r_count != 8'hFF)) begin
            r_count <= r_count + 8'h01;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/minirisc_driver.sv
// Drives one operand into the tt_um_minirisc core, checks its echo and sum,
// and hands the sampled sum back to the host with pass/fail statistics.
module minirisc_driver
    import minirisc_pkg::*;
#(
    parameter logic [7:0] ADD_CONST = ADD_CONST_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] op_data,
    input  logic       op_valid,
    output logic       op_ready,
    output logic [7:0] res_data,
    output logic       res_err,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] dut_ui,
    input  logic [7:0] dut_uo,
    output logic       dut_ena,
    output logic       dut_rst_n,
    output logic [7:0] pass_cnt,
    output logic [7:0] fail_cnt
);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_operand;
    logic [7:0] r_ui;
    logic       r_rst_n;
    logic [7:0] r_res_data;
    logic       r_res_err;
    logic       r_echo_err;
    logic [7:0] w_sum_expect;
    logic       w_take;

    assign w_sum_expect = r_operand + ADD_CONST;
    assign w_take       = (r_state == ST_RESP) && res_ready && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (op_valid) w_state_next = (op_data == 8'h00) ? ST_RESP : ST_ISSUE1;
            ST_ISSUE1: w_state_next = ST_ISSUE2;
            ST_ISSUE2: w_state_next = ST_WAIT;
            ST_WAIT:   w_state_next = ST_ECHO;
            ST_ECHO:   w_state_next = ST_SUM;
            ST_SUM:    w_state_next = ST_RESP;
            ST_RESP:   if (res_ready) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_operand  <= 8'h00;
            r_ui       <= 8'h00;
            r_rst_n    <= 1'b0;
            r_res_data <= 8'h00;
            r_res_err  <= 1'b0;
            r_echo_err <= 1'b0;
        end else begin
            r_rst_n <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (op_valid) begin
                        // A zero operand is never issued; it becomes an immediate error result.
                        r_operand  <= op_data;
                        r_ui       <= op_data;
                        r_echo_err <= 1'b0;
                        if (op_data == 8'h00) begin
                            r_res_data <= 8'h00;
                            r_res_err  <= 1'b1;
                        end
                    end
                end
                ST_ISSUE2: r_ui <= 8'h00;
                ST_ECHO:   r_echo_err <= (dut_uo != r_operand);
                ST_SUM: begin
                    r_res_data <= dut_uo;
                    r_res_err  <= r_echo_err || (dut_uo != w_sum_expect);
                end
                default: ;
            endcase
        end
    end

    sat_counter8 u_pass_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (w_take && !r_res_err),
        .count (pass_cnt)
    );

    sat_counter8 u_fail_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (w_take && r_res_err),
        .count (fail_cnt)
    );

    assign op_ready  = (r_state == ST_IDLE) && !rst;
    assign res_valid = (r_state == ST_RESP);
    assign res_data  = r_res_data;
    assign res_err   = r_res_err;
    assign dut_ui    = r_ui;
    assign dut_ena   = !rst;
    assign dut_rst_n = r_rst_n;

endmodule

// File: tb/tb_minirisc_driver.sv
// Directed bench for minirisc_driver with a behavioural core model that can
// be switched into faulty-sum or faulty-echo modes.
module tb_minirisc_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] op_data;
    logic       op_valid;
    logic       op_ready;
    logic [7:0] res_data;
    logic       res_err;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] dut_ui;
    logic [7:0] dut_uo;
    logic       dut_ena;
    logic       dut_rst_n;
    logic [7:0] pass_cnt;
    logic [7:0] fail_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    minirisc_driver #(.ADD_CONST(8'h08)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_data   (op_data),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .res_data  (res_data),
        .res_err   (res_err),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .dut_ui    (dut_ui),
        .dut_uo    (dut_uo),
        .dut_ena   (dut_ena),
        .dut_rst_n (dut_rst_n),
        .pass_cnt  (pass_cnt),
        .fail_cnt  (fail_cnt)
    );

    // Core model: captures a non-zero ui_in, echoes it two edges later, then
    // presents the sum. mode 1 returns operand+7, mode 2 corrupts the echo.
    int         core_mode = 0;
    logic [7:0] core_val;
    logic [2:0] core_cnt;

    always @(posedge clk) begin
        if (!dut_rst_n) begin
            core_val <= 8'h00;
            core_cnt <= 3'd0;
        end else if (core_cnt == 3'd0) begin
            if (dut_ui != 8'h00) begin
                core_val <= dut_ui;
                core_cnt <= 3'd1;
            end
        end else if (core_cnt == 3'd5) begin
            core_cnt <= 3'd0;
        end else begin
            core_cnt <= core_cnt + 3'd1;
        end
    end

    assign dut_uo = (core_cnt == 3'd3) ? ((core_mode == 2) ? (core_val ^ 8'h01) : core_val) :
                    (core_cnt == 3'd4) ? ((core_mode == 1) ? (core_val + 8'h07) : (core_val + 8'h08)) :
                    8'h00;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offers one operand and counts edges (accept edge included) until res_valid.
    task automatic do_op(input logic [7:0] op, output int lat);
        op_data  = op;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic take();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int acc;
        int t_acc[3];

        rst       = 1'b1;
        op_data   = 8'h00;
        op_valid  = 1'b0;
        res_ready = 1'b0;
        tick();
        tick();
        chk("rst_op_ready", op_ready, 0);
        chk("rst_dut_rst_n", dut_rst_n, 0);
        chk("rst_dut_ena", dut_ena, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_dut_ui", dut_ui, 0);
        chk("rst_pass_cnt", pass_cnt, 0);
        chk("rst_fail_cnt", fail_cnt, 0);

        rst = 1'b0;
        tick();
        chk("post_rst_dut_rst_n", dut_rst_n, 1);
        chk("post_rst_dut_ena", dut_ena, 1);
        chk("post_rst_op_ready", op_ready, 1);

        // Operand 0x10, stepped edge by edge.
        op_data  = 8'h10;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        chk("op10_ui_e0", dut_ui, 8'h10);
        chk("op10_busy", op_ready, 0);
        tick();
        chk("op10_ui_e1", dut_ui, 8'h10);
        tick();
        chk("op10_ui_e2", dut_ui, 8'h00);
        tick();
        tick();
        chk("op10_valid_e4", res_valid, 0);
        tick();
        chk("op10_valid_e5", res_valid, 1);
        chk("op10_data", res_data, 8'h18);
        chk("op10_err", res_err, 0);
        take();
        chk("op10_valid_after_take", res_valid, 0);
        chk("op10_pass_cnt", pass_cnt, 1);
        chk("op10_op_ready", op_ready, 1);

        do_op(8'hFC, lat);
        chk("opFC_latency", lat, 6);
        chk("opFC_data", res_data, 8'h04);
        chk("opFC_err", res_err, 0);
        take();
        chk("opFC_pass_cnt", pass_cnt, 2);

        do_op(8'h00, lat);
        chk("op00_latency", lat, 1);
        chk("op00_ui", dut_ui, 8'h00);
        chk("op00_data", res_data, 8'h00);
        chk("op00_err", res_err, 1);
        take();
        chk("op00_fail_cnt", fail_cnt, 1);

        core_mode = 1;
        do_op(8'h20, lat);
        chk("badsum_latency", lat, 6);
        chk("badsum_data", res_data, 8'h27);
        chk("badsum_err", res_err, 1);
        take();
        chk("badsum_fail_cnt", fail_cnt, 2);

        core_mode = 2;
        do_op(8'h30, lat);
        chk("badecho_data", res_data, 8'h38);
        chk("badecho_err", res_err, 1);
        take();
        chk("badecho_fail_cnt", fail_cnt, 3);
        chk("badecho_pass_cnt", pass_cnt, 2);

        // Result held while the host stalls; a competing operand is ignored.
        core_mode = 0;
        do_op(8'h40, lat);
        chk("hold_latency", lat, 6);
        op_data  = 8'hAA;
        op_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hold_valid", res_valid, 1);
            chk("hold_data", res_data, 8'h48);
            chk("hold_err", res_err, 0);
            chk("hold_op_ready", op_ready, 0);
        end
        op_valid = 1'b0;
        take();
        chk("hold_pass_cnt", pass_cnt, 3);

        // Back-to-back operands with res_ready held high.
        res_ready = 1'b1;
        op_valid  = 1'b1;
        op_data   = 8'h01;
        acc       = 0;
        for (int c = 0; c < 60 && acc < 3; c++) begin
            if (op_ready) begin
                t_acc[acc] = c;
                acc++;
            end
            tick();
            op_data = 8'(acc + 1);
        end
        op_valid = 1'b0;
        chk("b2b_accepts", acc, 3);
        chk("b2b_spacing_01", t_acc[1] - t_acc[0], 7);
        chk("b2b_spacing_12", t_acc[2] - t_acc[1], 7);
        repeat (10) tick();
        chk("b2b_pass_cnt", pass_cnt, 6);
        chk("b2b_fail_cnt", fail_cnt, 3);
        res_ready = 1'b0;

        // Reset while the transaction sits in WAIT.
        op_data  = 8'h55;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("abort_dut_rst_n_low", dut_rst_n, 0);
        chk("abort_op_ready", op_ready, 0);
        chk("abort_res_valid", res_valid, 0);
        rst = 1'b0;
        tick();
        chk("abort_dut_rst_n_high", dut_rst_n, 1);
        chk("abort_pass_cnt", pass_cnt, 0);
        chk("abort_fail_cnt", fail_cnt, 0);
        repeat (8) tick();
        chk("abort_no_result", res_valid, 0);
        chk("abort_idle", op_ready, 1);

        do_op(8'h01, lat);
        chk("after_abort_latency", lat, 6);
        chk("after_abort_data", res_data, 8'h09);
        chk("after_abort_err", res_err, 0);
        take();
        chk("after_abort_pass_cnt", pass_cnt, 1);

        // Drive fail_cnt past 255 with a stream of zero operands.
        res_ready = 1'b1;
        op_valid  = 1'b1;
        op_data   = 8'h00;
        repeat (600) tick();
        op_valid  = 1'b0;
        tick();
        tick();
        res_ready = 1'b0;
        chk("sat_fail_cnt", fail_cnt, 8'hFF);
        chk("sat_pass_cnt", pass_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
